fetch_pc: RTL and testbench
===========================

Name: fetch_pc

Overview:
Parametrised next-generation program counter for the MIPS fetch stage; drives the instruction-ROM address each cycle.
Adds a configurable reset vector, an exception/flush redirect with priority over branches, and a pending-redirect latch so a branch resolved during a stall is not lost.
Sits between the pipeline control unit (stall/flush) and the instruction ROM/IF register.

Parameters:
ADDR_W, 32, instruction address width in bits
INST_BYTES, 4, byte increment per instruction; power of two
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
BTB_DEPTH, 16, BTB entries; power of two; used only with PC_BTB_EN

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
stall_i  in  1  hold PC (IF stall, bit 0 of the control stall vector)
flush_i  in  1  exception/eret redirect; overrides stall
flush_target_i  in  ADDR_W  flush destination
br_taken_i  in  1  branch/jump resolved taken
br_target_i  in  ADDR_W  branch destination
upd_valid_i  in  1  BTB update strobe (ignored without PC_BTB_EN)
upd_pc_i  in  ADDR_W  branch instruction address for BTB update
upd_target_i  in  ADDR_W  taken target for BTB update
pc_o  out  ADDR_W  current fetch address to ROM
pc_valid_o  out  1  pc_o is a real fetch
pend_o  out  1  a redirect is latched, waiting for stall release
pred_hit_o  out  1  pc_o was produced by a BTB prediction

Behaviour:
- Reset (rst_n=0 at posedge): pc_o=RESET_VECTOR, pc_valid_o=0, pend_o=0, pred_hit_o=0, pending target=0. Reset mid-operation discards any pending redirect.
- First cycle after reset release: pc_valid_o<=1 and pc_o holds RESET_VECTOR. This is the one-cycle start-up delay. The first valid fetch is therefore RESET_VECTOR.
- While pc_valid_o=0: flush_i, br_taken_i and upd_valid_i are ignored.
- Next-PC priority per posedge when valid:
  1. flush_i: pc_o<=flush_target_i; pending cleared. Applies even while stall_i=1.
  2. stall_i=1: pc_o holds. If br_taken_i, latch br_target_i into pending and set pend_o=1; a later branch in the same stall overwrites it.
  3. br_taken_i (not stalled): pc_o<=br_target_i; pending cleared.
  4. pend_o=1 (not stalled): pc_o<=pending target; pend_o<=0.
  5. Otherwise pc_o<=pc_o+INST_BYTES, modulo 2^ADDR_W (0xFFFF_FFFC wraps to 0x0000_0000).
- All targets have their low log2(INST_BYTES) bits forced to 0 before use.
- Redirect latency: one cycle. A target presented at edge N appears on pc_o after edge N.
- pend_o and the pending target are registered; no combinational path exists from inputs to pc_o.

Optional Feature:
Macro PC_BTB_EN.
- Defined:
  - Adds a direct-mapped BTB with BTB_DEPTH entries of {valid, tag, target}.
  - Index = pc_o[log2(INST_BYTES)+:log2(BTB_DEPTH)]; tag = the remaining upper bits.
  - Priority step 5 becomes: on a hit, pc_o<=stored target and pred_hit_o<=1; otherwise sequential with pred_hit_o<=0.
  - upd_valid_i writes an entry at the posedge and is visible to lookups from the next cycle. An update and a lookup to the same index in the same cycle return the old entry.
  - Reset clears all valid bits.
- Undefined: upd_* ports are unused and pred_hit_o is tied 0.

Decomposition:
- Shared package holds: ADDR_W default, INST_BYTES, RESET_VECTOR default, the priority encoding for the next-PC source (FLUSH, BRANCH, PENDING, PRED, SEQ), and a CLOG2 helper.
- One sub-module, fetch_btb (BTB storage and lookup), is instantiated only under PC_BTB_EN.

Test Plan:
- Reset with RESET_VECTOR=0xBFC00000, release → pc_o=0xBFC00000 with valid 0 for 1 cycle, then valid 1; subsequent cycles 0xBFC00004, 0xBFC00008.
- Running at 0x100, br_taken_i=1 with target 0x200 → next pc_o=0x200, then 0x204.
- stall_i=1 for 3 cycles at 0x40, with br_taken_i pulsed to 0x80 in cycle 1 and to 0x90 in cycle 2 → pc_o holds 0x40, pend_o=1; after release pc_o=0x90, pend_o=0.
- Stall with pending 0x80, then flush_i to 0x180 while still stalled → pc_o=0x180, pend_o=0; the pending 0x80 is never fetched.
- pc_o=0xFFFFFFFC with no events → pc_o=0x00000000. br_target_i=0x203 → pc_o=0x200.
- PC_BTB_EN: update (0x100→0x300), then reach 0x100 → next pc_o=0x300 with pred_hit_o=1. Reset, then reach 0x100 → 0x104 with pred_hit_o=0.

Source files
------------

// File: rtl/fetch_pc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pc_pkg
// Purpose : Shared definitions for the MIPS fetch-stage program counter.
//           Holds the default geometry, the next-PC source encoding and a
//           ceil(log2) helper used to size index and offset fields.
// Ports   : none (package)
// Macros  : none here; see fetch_pc for PC_BTB_EN
// Revision: 1.0 - initial release
// ============================================================================
package fetch_pc_pkg;

    localparam int          PC_ADDR_W       = 32;
    localparam int          PC_INST_BYTES   = 4;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam int          PC_BTB_DEPTH    = 16;

    // Next-PC source, listed in decreasing priority. HOLD covers the stall
    // case, where pc_o keeps its value and a branch may be parked instead.
    typedef enum logic [2:0] {
        SRC_FLUSH   = 3'd0,
        SRC_HOLD    = 3'd1,
        SRC_BRANCH  = 3'd2,
        SRC_PENDING = 3'd3,
        SRC_PRED    = 3'd4,
        SRC_SEQ     = 3'd5
    } pc_src_e;

    // ceil(log2(n)); returns 0 for n <= 1.
    function automatic int CLOG2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : fetch_pc_pkg
`default_nettype wire

// File: rtl/fetch_btb.sv
`default_nettype none
// ============================================================================
// Module  : fetch_btb
// Purpose : Direct-mapped branch target buffer for the fetch PC.
//           Each entry is {valid, tag, target}. Lookup is combinational off
//           registered storage, so a same-cycle update to the looked-up
//           index returns the old entry; the new one is seen next cycle.
// Ports   : clk, rst_n          clock, synchronous active-low reset
//           lookup_pc_i         address being looked up (current pc_o)
//           hit_o, target_o     lookup result
//           upd_valid_i         write strobe
//           upd_pc_i            branch address to store
//           upd_target_i        taken target to store
// Macros  : instantiated only when PC_BTB_EN is defined
// Revision: 1.0 - initial release
// ============================================================================
module fetch_btb
    import fetch_pc_pkg::*;
#(
    parameter int ADDR_W     = PC_ADDR_W,
    parameter int INST_BYTES = PC_INST_BYTES,
    parameter int BTB_DEPTH  = PC_BTB_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              hit_o,
    output logic [ADDR_W-1:0] target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic [ADDR_W-1:0] upd_target_i
);

    localparam int OFF_W   = CLOG2(INST_BYTES);
    localparam int IDX_W   = CLOG2(BTB_DEPTH);
    localparam int TAG_LSB = OFF_W + IDX_W;
    localparam int TAG_W   = ADDR_W - TAG_LSB;

    logic [BTB_DEPTH-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
    logic [ADDR_W-1:0]    tgt_q [BTB_DEPTH];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_unused_lsb;

    assign w_lk_idx = lookup_pc_i[OFF_W +: IDX_W];
    assign w_lk_tag = lookup_pc_i[ADDR_W-1:TAG_LSB];
    assign w_up_idx = upd_pc_i[OFF_W +: IDX_W];
    assign w_up_tag = upd_pc_i[ADDR_W-1:TAG_LSB];

    // Byte-offset bits never take part in indexing or tagging.
    assign w_unused_lsb = ^(lookup_pc_i ^ upd_pc_i);

    assign hit_o    = valid_q[w_lk_idx] && (tag_q[w_lk_idx] == w_lk_tag);
    assign target_o = tgt_q[w_lk_idx];

    // Only the valid bits need a reset; tag/target are qualified by them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (upd_valid_i) begin
            valid_q[w_up_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_valid_i) begin
            tag_q[w_up_idx] <= w_up_tag;
            tgt_q[w_up_idx] <= upd_target_i;
        end
    end

endmodule : fetch_btb
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pc
// Purpose : Next-PC generator for the MIPS fetch stage. Drives the
//           instruction-ROM address each cycle with a configurable reset
//           vector, a flush redirect that beats stalls and branches, and a
//           pending-redirect latch that keeps a branch resolved during a
//           stall until the stall releases.
// Ports   : clk, rst_n              clock, synchronous active-low reset
//           stall_i                 hold PC
//           flush_i/flush_target_i  exception/eret redirect (beats stall)
//           br_taken_i/br_target_i  resolved taken branch
//           upd_valid_i/upd_pc_i/upd_target_i  BTB update (PC_BTB_EN only)
//           pc_o                    current fetch address
//           pc_valid_o              pc_o is a real fetch
//           pend_o                  a redirect is parked behind a stall
//           pred_hit_o              pc_o came from a BTB prediction
// Macros  : PC_BTB_EN - adds the fetch_btb predictor; without it the upd_*
//           ports are ignored and pred_hit_o stays 0.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_pc
    import fetch_pc_pkg::*;
#(
    parameter int                ADDR_W       = PC_ADDR_W,
    parameter int                INST_BYTES   = PC_INST_BYTES,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(PC_RESET_VECTOR),
    parameter int                BTB_DEPTH    = PC_BTB_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_target_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    output logic              pend_o,
    output logic              pred_hit_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);

    logic [ADDR_W-1:0] pc_q,       pc_d;
    logic              valid_q;
    logic              pend_q,     pend_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              hit_q,      hit_d;

    logic [ADDR_W-1:0] w_flush_tgt;
    logic [ADDR_W-1:0] w_br_tgt;
    logic              w_pred_hit;
    logic [ADDR_W-1:0] w_pred_tgt;
    pc_src_e           w_src;

    assign w_flush_tgt = flush_target_i & ALIGN_MASK;
    assign w_br_tgt    = br_target_i    & ALIGN_MASK;

`ifdef PC_BTB_EN
    logic [ADDR_W-1:0] w_btb_tgt;

    // Updates are ignored until the first valid fetch cycle.
    fetch_btb #(
        .ADDR_W     (ADDR_W),
        .INST_BYTES (INST_BYTES),
        .BTB_DEPTH  (BTB_DEPTH)
    ) u_btb (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_pc_i  (pc_q),
        .hit_o        (w_pred_hit),
        .target_o     (w_btb_tgt),
        .upd_valid_i  (upd_valid_i & valid_q),
        .upd_pc_i     (upd_pc_i),
        .upd_target_i (upd_target_i)
    );

    assign w_pred_tgt = w_btb_tgt & ALIGN_MASK;
`else
    logic w_unused_upd;

    assign w_unused_upd = ^{upd_valid_i, upd_pc_i, upd_target_i};
    assign w_pred_hit   = 1'b0;
    assign w_pred_tgt   = '0;
`endif

    // Source selection in priority order.
    always_comb begin
        w_src = SRC_SEQ;
        if (flush_i) begin
            w_src = SRC_FLUSH;
        end else if (stall_i) begin
            w_src = SRC_HOLD;
        end else if (br_taken_i) begin
            w_src = SRC_BRANCH;
        end else if (pend_q) begin
            w_src = SRC_PENDING;
        end else if (w_pred_hit) begin
            w_src = SRC_PRED;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        hit_d      = hit_q;
        case (w_src)
            SRC_FLUSH: begin
                pc_d       = w_flush_tgt;
                pend_d     = 1'b0;
                pend_tgt_d = '0;
                hit_d      = 1'b0;
            end
            SRC_HOLD: begin
                // pc_o (and its prediction flag) hold; the latest branch
                // seen during the stall wins the pending slot.
                if (br_taken_i) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = w_br_tgt;
                end
            end
            SRC_BRANCH: begin
                pc_d       = w_br_tgt;
                pend_d     = 1'b0;
                pend_tgt_d = '0;
                hit_d      = 1'b0;
            end
            SRC_PENDING: begin
                pc_d       = pend_tgt_q;
                pend_d     = 1'b0;
                pend_tgt_d = '0;
                hit_d      = 1'b0;
            end
            SRC_PRED: begin
                pc_d  = w_pred_tgt;
                hit_d = 1'b1;
            end
            default: begin
                pc_d  = pc_q + PC_STEP;
                hit_d = 1'b0;
            end
        endcase
    end

    // The first cycle out of reset only raises valid, so the first real
    // fetch is RESET_VECTOR; redirect inputs are ignored until then.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            hit_q      <= 1'b0;
        end else if (!valid_q) begin
            valid_q    <= 1'b1;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            hit_q      <= hit_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = valid_q;
    assign pend_o     = pend_q;
    assign pred_hit_o = hit_q;

endmodule : fetch_pc
`default_nettype wire

// File: tb/tb_fetch_pc.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_pc
// Purpose : Self-checking bench for fetch_pc. Each step drives one cycle of
//           inputs, queues the expected outputs, and compares them after
//           the active edge. BTB expectations depend on PC_BTB_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_pc;

    localparam int          AW = 32;
    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall_i;
    logic          flush_i;
    logic [AW-1:0] flush_target_i;
    logic          br_taken_i;
    logic [AW-1:0] br_target_i;
    logic          upd_valid_i;
    logic [AW-1:0] upd_pc_i;
    logic [AW-1:0] upd_target_i;
    logic [AW-1:0] pc_o;
    logic          pc_valid_o;
    logic          pend_o;
    logic          pred_hit_o;

    always #5 clk = ~clk;

    fetch_pc #(
        .ADDR_W       (AW),
        .INST_BYTES   (4),
        .RESET_VECTOR (RV),
        .BTB_DEPTH    (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .flush_target_i (flush_target_i),
        .br_taken_i     (br_taken_i),
        .br_target_i    (br_target_i),
        .upd_valid_i    (upd_valid_i),
        .upd_pc_i       (upd_pc_i),
        .upd_target_i   (upd_target_i),
        .pc_o           (pc_o),
        .pc_valid_o     (pc_valid_o),
        .pend_o         (pend_o),
        .pred_hit_o     (pred_hit_o)
    );

    typedef struct {
        string       name;
        logic        rst_n;
        logic        stall;
        logic        flush;
        logic [31:0] ftgt;
        logic        br;
        logic [31:0] btgt;
        logic        upd;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic [31:0] epc;
        logic        ev;
        logic        ep;
        logic        eh;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(string name, logic stall, logic flush,
                                logic [31:0] ftgt, logic br, logic [31:0] btgt,
                                logic [31:0] epc, logic ep);
        vec_t v;
        v.name = name; v.rst_n = 1'b1; v.stall = stall; v.flush = flush;
        v.ftgt = ftgt; v.br = br; v.btgt = btgt;
        v.upd = 1'b0; v.upc = '0; v.utgt = '0;
        v.epc = epc; v.ev = 1'b1; v.ep = ep; v.eh = 1'b0;
        return v;
    endfunction

    function automatic vec_t mk_rst(string name, logic [31:0] epc, logic ev);
        vec_t v;
        v = mk(name, 1'b0, 1'b0, '0, 1'b0, '0, epc, 1'b0);
        v.rst_n = 1'b0;
        v.ev    = ev;
        return v;
    endfunction

    task automatic chk(input string name, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, what, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst_n          = v.rst_n;
        stall_i        = v.stall;
        flush_i        = v.flush;
        flush_target_i = v.ftgt;
        br_taken_i     = v.br;
        br_target_i    = v.btgt;
        upd_valid_i    = v.upd;
        upd_pc_i       = v.upc;
        upd_target_i   = v.utgt;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.name, "pc",    pc_o,               e.epc);
        chk(e.name, "valid", {31'b0, pc_valid_o}, {31'b0, e.ev});
        chk(e.name, "pend",  {31'b0, pend_o},     {31'b0, e.ep});
        chk(e.name, "hit",   {31'b0, pred_hit_o}, {31'b0, e.eh});
    endtask

    initial begin
        vec_t v;

        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; flush_target_i = '0;
        br_taken_i = 1'b0; br_target_i = '0; upd_valid_i = 1'b0;
        upd_pc_i = '0; upd_target_i = '0;

        // ---- Reset and start-up ----
        v = mk_rst("rst0", RV, 1'b0); v.flush = 1'b1; v.ftgt = 32'h500; step(v);
        v = mk_rst("rst1", RV, 1'b0); v.stall = 1'b1; v.br = 1'b1; v.btgt = 32'h40; step(v);
        // Redirects are ignored in the start-up cycle.
        step(mk("start", 1'b0, 1'b1, 32'h500, 1'b1, 32'h600, RV, 1'b0));
        step(mk("seq1",  1'b0, 1'b0, '0, 1'b0, '0, RV + 32'h4, 1'b0));
        step(mk("seq2",  1'b0, 1'b0, '0, 1'b0, '0, RV + 32'h8, 1'b0));

        // ---- Main vector table ----
        tbl.push_back(mk("fl_fc",    0, 1, 32'hFC,  0, '0,      32'h0000_00FC, 0));
        tbl.push_back(mk("to100",    0, 0, '0,      0, '0,      32'h0000_0100, 0));
        tbl.push_back(mk("br200",    0, 0, '0,      1, 32'h200, 32'h0000_0200, 0));
        tbl.push_back(mk("to204",    0, 0, '0,      0, '0,      32'h0000_0204, 0));
        tbl.push_back(mk("fl_40",    0, 1, 32'h40,  0, '0,      32'h0000_0040, 0));
        tbl.push_back(mk("st_br80",  1, 0, '0,      1, 32'h80,  32'h0000_0040, 1));
        tbl.push_back(mk("st_br90",  1, 0, '0,      1, 32'h90,  32'h0000_0040, 1));
        tbl.push_back(mk("st_idle",  1, 0, '0,      0, '0,      32'h0000_0040, 1));
        tbl.push_back(mk("rel_90",   0, 0, '0,      0, '0,      32'h0000_0090, 0));
        tbl.push_back(mk("to94",     0, 0, '0,      0, '0,      32'h0000_0094, 0));
        tbl.push_back(mk("st_br80b", 1, 0, '0,      1, 32'h80,  32'h0000_0094, 1));
        tbl.push_back(mk("st_fl180", 1, 1, 32'h180, 0, '0,      32'h0000_0180, 0));
        tbl.push_back(mk("st_hold",  1, 0, '0,      0, '0,      32'h0000_0180, 0));
        tbl.push_back(mk("to184",    0, 0, '0,      0, '0,      32'h0000_0184, 0));
        tbl.push_back(mk("st_br300", 1, 0, '0,      1, 32'h300, 32'h0000_0184, 1));
        tbl.push_back(mk("br_over",  0, 0, '0,      1, 32'h400, 32'h0000_0400, 0));
        tbl.push_back(mk("to404",    0, 0, '0,      0, '0,      32'h0000_0404, 0));
        tbl.push_back(mk("fl_vs_br", 0, 1, 32'h600, 1, 32'h700, 32'h0000_0600, 0));
        tbl.push_back(mk("fl_top",   0, 1, 32'hFFFF_FFF8, 0, '0, 32'hFFFF_FFF8, 0));
        tbl.push_back(mk("to_fffc",  0, 0, '0,      0, '0,      32'hFFFF_FFFC, 0));
        tbl.push_back(mk("wrap",     0, 0, '0,      0, '0,      32'h0000_0000, 0));
        tbl.push_back(mk("br_203",   0, 0, '0,      1, 32'h203, 32'h0000_0200, 0));
        tbl.push_back(mk("fl_1007",  0, 1, 32'h1007, 0, '0,     32'h0000_1004, 0));
        tbl.push_back(mk("st_br2a2", 1, 0, '0,      1, 32'h2A2, 32'h0000_1004, 1));
        tbl.push_back(mk("rel_2a0",  0, 0, '0,      0, '0,      32'h0000_02A0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // ---- Reset mid-operation drops the pending redirect ----
        step(mk("m_fl700",  0, 1, 32'h700, 0, '0,      32'h700, 0));
        step(mk("m_st800",  1, 0, '0,      1, 32'h800, 32'h700, 1));
        step(mk_rst("m_rst", RV, 1'b0));
        step(mk("m_start",  0, 0, '0,      0, '0,      RV,         0));
        step(mk("m_seq",    0, 0, '0,      0, '0,      RV + 32'h4, 0));

        // ---- BTB prediction ----
        v = mk("b_upd", 0, 1, 32'hF8, 0, '0, 32'hF8, 0);
        v.upd = 1'b1; v.upc = 32'h100; v.utgt = 32'h300;
        step(v);
        step(mk("b_fc",   0, 0, '0, 0, '0, 32'hFC,  0));
        step(mk("b_100",  0, 0, '0, 0, '0, 32'h100, 0));
`ifdef PC_BTB_EN
        v = mk("b_pred", 0, 0, '0, 0, '0, 32'h300, 0); v.eh = 1'b1; step(v);
        step(mk("b_after", 0, 0, '0, 0, '0, 32'h304, 0));
`else
        step(mk("b_pred",  0, 0, '0, 0, '0, 32'h104, 0));
        step(mk("b_after", 0, 0, '0, 0, '0, 32'h108, 0));
`endif
        step(mk_rst("b_rst", RV, 1'b0));
        step(mk("b_start", 0, 0, '0,    0, '0, RV,      0));
        step(mk("b_fl_fc", 0, 1, 32'hFC, 0, '0, 32'hFC,  0));
        step(mk("b_100b",  0, 0, '0,    0, '0, 32'h100, 0));
        step(mk("b_nopred",0, 0, '0,    0, '0, 32'h104, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_pc
`default_nettype wire
